// File: rtl/range_logger_pkg.sv
// Shared types and default sizes for the range logger.
package range_logger_pkg;

  localparam int unsigned DEF_WIDTH = 9;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } logger_state_t;

endpackage

// File: rtl/range_log_fifo.sv
// History storage for range_logger: circular buffer with explicit pointer wrap.
// The caller gates push against full and pop against empty.
module range_log_fifo
  import range_logger_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_word,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage carries no reset; a zero count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_word = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/range_logger.sv
// Range result history: FIFO capture, host pop/dump, sticky overflow.
// Define RANGE_LOGGER_MAX_EN to track the largest accepted range in max_range.
module range_logger
  import range_logger_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           range_in,
  input  logic                       range_valid,
  input  logic                       rd_en,
  input  logic                       dump,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [WIDTH-1:0]           max_range
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logger_state_t    state_q, state_d;
  logic             pop, push, drop;
  logic [WIDTH-1:0] rd_word;

  // A dump starting from IDLE pops in the same cycle it is seen.
  assign pop  = (((state_q == IDLE) && (rd_en || dump)) || (state_q == DRAIN)) && !empty;
  assign push = range_valid && (!full || pop);
  assign drop = range_valid && full && !pop;

  range_log_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (range_in),
    .rd_word (rd_word),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (dump && !empty) state_d = DRAIN;
      DRAIN: begin
        if (empty || (pop && !push && count == CW'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= pop;
      if (pop) rd_data <= rd_word;
      // A drop outranks a simultaneous clear so no loss goes unreported.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef RANGE_LOGGER_MAX_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_range <= '0;
    end else if (push && (range_in > max_range)) begin
      max_range <= range_in;
    end
  end
`else
  assign max_range = '0;
`endif

endmodule

// File: tb/tb_range_logger.sv
// Directed self-checking bench for range_logger (WIDTH=9, DEPTH=4).
module tb_range_logger;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] range_in;
  logic       range_valid, rd_en, dump, clr_ovf;
  logic [8:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       full, empty, overflow;
  logic [8:0] max_range;

  int n_cmp = 0;
  int n_err = 0;

  range_logger #(
    .WIDTH (9),
    .DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .range_in    (range_in),
    .range_valid (range_valid),
    .rd_en       (rd_en),
    .dump        (dump),
    .clr_ovf     (clr_ovf),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .max_range   (max_range)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [8:0] v);
    range_valid = 1'b1;
    range_in    = v;
    tick();
    range_valid = 1'b0;
  endtask

  task automatic check_pop(input string tag, input logic [8:0] v);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(v));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_max"}, 32'(max_range), 32'd0);
  endtask

  initial begin
    reset = 1'b1; range_in = '0; range_valid = 1'b0;
    rd_en = 1'b0; dump = 1'b0; clr_ovf = 1'b0;
    #12;
    check_reset_state("rst");
    reset = 1'b0;

    // 1: gapped pushes, then three pops
    push_one(9'd5); tick();
    push_one(9'd9); tick();
    push_one(9'd2); tick();
    check("t1_count", 32'(count), 32'd3);
    rd_en = 1'b1;
    tick(); check_pop("t1_p0", 9'd5);
    tick(); check_pop("t1_p1", 9'd9);
    tick(); check_pop("t1_p2", 9'd2);
    rd_en = 1'b0;
    tick();
    check("t1_valid_low", 32'(rd_valid), 32'd0);
    check("t1_data_hold", 32'(rd_data), 32'd2);
    check("t1_empty", 32'(empty), 32'd1);

    // 2: fill, drop with simultaneous clear, then clear
    push_one(9'd1); push_one(9'd2); push_one(9'd3); push_one(9'd4);
    check("t2_full", 32'(full), 32'd1);
    check("t2_count", 32'(count), 32'd4);
    clr_ovf = 1'b1;
    push_one(9'd400);
    clr_ovf = 1'b0;
    check("t2_ovf_set", 32'(overflow), 32'd1);
    check("t2_count_drop", 32'(count), 32'd4);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);
    rd_en = 1'b1;
    tick(); check_pop("t2_p0", 9'd1);
    tick(); check_pop("t2_p1", 9'd2);
    tick(); check_pop("t2_p2", 9'd3);
    tick(); check_pop("t2_p3", 9'd4);
    rd_en = 1'b0;
    tick();
    check("t2_empty", 32'(empty), 32'd1);

    // 3: push and pop together while full
    push_one(9'd10); push_one(9'd11); push_one(9'd12); push_one(9'd13);
    range_valid = 1'b1; range_in = 9'd8; rd_en = 1'b1;
    tick();
    range_valid = 1'b0; rd_en = 1'b0;
    check_pop("t3_pop", 9'd10);
    check("t3_count", 32'(count), 32'd4);
    check("t3_ovf", 32'(overflow), 32'd0);

    // 4: dump with rd_en held high throughout
    dump = 1'b1; rd_en = 1'b1;
    tick(); dump = 1'b0;
    check_pop("t4_d0", 9'd11);
    tick(); check_pop("t4_d1", 9'd12);
    tick(); check_pop("t4_d2", 9'd13);
    tick(); check_pop("t4_d3", 9'd8);
    check("t4_empty", 32'(empty), 32'd1);
    tick();
    check("t4_no_extra", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    push_one(9'd20); tick();
    check("t4_idle_count", 32'(count), 32'd1);
    check("t4_idle_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_pop("t4_pop20", 9'd20);

    // 5: pop on empty, zero-valued entry
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t5_empty_pop", 32'(rd_valid), 32'd0);
    push_one(9'd0);
    check("t5_count", 32'(count), 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_pop("t5_pop0", 9'd0);

    // 6: reset mid-dump, then max tracking
    push_one(9'd6); push_one(9'd7); push_one(9'd8);
`ifdef RANGE_LOGGER_MAX_EN
    check("t6_max_pre", 32'(max_range), 32'd20);
`else
    check("t6_max_pre", 32'(max_range), 32'd0);
`endif
    dump = 1'b1; tick(); dump = 1'b0;
    check_pop("t6_d0", 9'd6);
    tick();
    check_pop("t6_d1", 9'd7);
    #2 reset = 1'b1;
    #1 check_reset_state("t6_rst");
    reset = 1'b0;
    push_one(9'd4); push_one(9'd300); push_one(9'd12);
    tick();
    check("t6_count", 32'(count), 32'd3);
    check("t6_no_drain", 32'(rd_valid), 32'd0);
`ifdef RANGE_LOGGER_MAX_EN
    check("t6_max", 32'(max_range), 32'd300);
`else
    check("t6_max", 32'(max_range), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
